// File: rtl/display_mode_ctrl.sv
// display_mode_ctrl: frame-aligned display mode selector.
// Two debounced push buttons step a target mode forward/back with wrap. The
// target is applied to mode_sel only at a frame start. Mute is then held for
// SETTLE_FRAMES frame starts so the sink never shows a torn frame.
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   key_next_n - raw active-low "next mode" button
//   key_prev_n - raw active-low "previous mode" button
//   vsync_in   - frame sync, asynchronous to clk, active-high
//   mode_sel   - selector code for the display channel multiplexer
//   mute       - force display data to black while high
//   busy       - a mode change is pending or settling
module display_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned MODE_MAX        = 7,
  parameter int unsigned DEFAULT_MODE    = 0,
  parameter int unsigned SETTLE_FRAMES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_next_n,
  input  logic       key_prev_n,
  input  logic       vsync_in,
  output logic [3:0] mode_sel,
  output logic       mute,
  output logic       busy
);

  localparam int unsigned      CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       MaxMode = 4'(MODE_MAX);
  localparam logic [3:0]       DefMode = 4'(DEFAULT_MODE);
  localparam logic [3:0]       Settle  = 4'(SETTLE_FRAMES);

  typedef enum logic [1:0] {Idle, Pend, Settling} state_t;

  // Frame-start detection: two sync flops plus one history flop for the edge.
  logic vs_s1, vs_s2, vs_s3, fs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
      vs_s3 <= 1'b0;
    end else begin
      vs_s1 <= vsync_in;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
    end
  end

  assign fs = vs_s2 & ~vs_s3;

  // Key debouncers, index 0 = next, 1 = prev. Levels idle high (released).
  logic [1:0]           key_s1, key_s2, key_lvl, key_ev;
  logic [1:0][CntW-1:0] key_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1  <= 2'b11;
      key_s2  <= 2'b11;
      key_lvl <= 2'b11;
      key_ev  <= 2'b00;
      key_cnt <= '0;
    end else begin
      key_s1 <= {key_prev_n, key_next_n};
      key_s2 <= key_s1;
      for (int i = 0; i < 2; i++) begin
        key_ev[i] <= 1'b0;
        if (key_s2[i] != key_lvl[i]) begin
          if (key_cnt[i] == CntLast) begin
            key_lvl[i] <= key_s2[i];
            key_cnt[i] <= '0;
            // Old level high means this acceptance is a press.
            key_ev[i]  <= key_lvl[i];
          end else begin
            key_cnt[i] <= key_cnt[i] + 1'b1;
          end
        end else begin
          key_cnt[i] <= '0;
        end
      end
    end
  end

  // Simultaneous presses cancel each other.
  logic ev, ev_up;
  assign ev    = key_ev[0] ^ key_ev[1];
  assign ev_up = key_ev[0];

  function automatic logic [3:0] step(input logic [3:0] m, input logic up);
    if (up) return (m == MaxMode) ? 4'd0 : m + 4'd1;
    else    return (m == 4'd0) ? MaxMode : m - 4'd1;
  endfunction

  state_t     state;
  logic [3:0] target;
  logic [3:0] fcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= Idle;
      target   <= DefMode;
      fcnt     <= 4'd0;
      mode_sel <= DefMode;
      mute     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        Idle: begin
          if (ev) begin
            target <= step(mode_sel, ev_up);
            busy   <= 1'b1;
            state  <= Pend;
          end
        end
        Pend: begin
          if (fs) begin
            // A coincident key event retargets before the apply.
            mode_sel <= ev ? step(target, ev_up) : target;
            target   <= ev ? step(target, ev_up) : target;
            mute     <= 1'b1;
            fcnt     <= 4'd0;
            state    <= Settling;
          end else if (ev) begin
            target <= step(target, ev_up);
          end
        end
        Settling: begin
          // target equals mode_sel here, so stepping target steps mode_sel.
          if (ev) begin
            target <= step(target, ev_up);
            state  <= Pend;
          end else if (fs) begin
            fcnt <= fcnt + 4'd1;
            if (fcnt + 4'd1 == Settle) begin
              mute  <= 1'b0;
              busy  <= 1'b0;
              state <= Idle;
            end
          end
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_display_mode_ctrl.sv
module tb_display_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_next_n = 1'b1;
  logic       key_prev_n = 1'b1;
  logic       vsync_in = 1'b0;
  logic [3:0] mode_sel;
  logic       mute;
  logic       busy;

  int errors = 0;
  int checks = 0;

  display_mode_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .MODE_MAX       (7),
    .DEFAULT_MODE   (0),
    .SETTLE_FRAMES  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_next_n(key_next_n),
    .key_prev_n(key_prev_n),
    .vsync_in  (vsync_in),
    .mode_sel  (mode_sel),
    .mute      (mute),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press (and release) with enough hold for the 4-cycle debounce.
  task automatic press(input logic nxt, input logic prv);
    @(negedge clk);
    key_next_n = ~nxt;
    key_prev_n = ~prv;
    wait_cyc(10);
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    wait_cyc(10);
  endtask

  task automatic frame();
    @(negedge clk);
    vsync_in = 1'b1;
    wait_cyc(4);
    vsync_in = 1'b0;
    wait_cyc(4);
  endtask

  task automatic check_out(input string tag, input int m, input int mu, input int b);
    check({tag, ".mode"}, int'(mode_sel), m);
    check({tag, ".mute"}, int'(mute), mu);
    check({tag, ".busy"}, int'(busy), b);
  endtask

  initial begin
    wait_cyc(3);
    check_out("reset_hold", 0, 0, 0);
    rst = 1'b0;
    wait_cyc(3);
    check_out("reset_rel", 0, 0, 0);

    // 3-cycle glitch is one sample short of acceptance.
    @(negedge clk);
    key_next_n = 1'b0;
    wait_cyc(3);
    key_next_n = 1'b1;
    wait_cyc(12);
    check_out("glitch", 0, 0, 0);

    // Basic next press and settle.
    press(1'b1, 1'b0);
    check_out("next_pend", 0, 0, 1);
    frame();
    check_out("next_apply", 1, 1, 1);
    frame();
    check_out("next_settle1", 1, 1, 1);
    frame();
    check_out("next_done", 1, 0, 0);

    // Six presses before a frame: 1 -> 7.
    for (int i = 0; i < 6; i++) press(1'b1, 1'b0);
    check_out("multi6_pend", 1, 0, 1);
    repeat (3) frame();
    check_out("to7", 7, 0, 0);

    // Wrap forward 7 -> 0 and back 0 -> 7.
    press(1'b1, 1'b0);
    frame();
    check_out("wrap_next_apply", 0, 1, 1);
    repeat (2) frame();
    check_out("wrap_next", 0, 0, 0);
    press(1'b0, 1'b1);
    repeat (3) frame();
    check_out("wrap_prev", 7, 0, 0);

    // 7 -> 2, then three presses collapse into one update to 5.
    repeat (3) press(1'b1, 1'b0);
    repeat (3) frame();
    check_out("to2", 2, 0, 0);
    repeat (3) press(1'b1, 1'b0);
    check_out("three_pend", 2, 0, 1);
    frame();
    check_out("three_apply", 5, 1, 1);
    repeat (2) frame();
    check_out("three_done", 5, 0, 0);

    // Both keys together cancel.
    press(1'b1, 1'b1);
    check_out("both_keys", 5, 0, 0);
    frame();
    check_out("both_keys_fs", 5, 0, 0);

    // Reset while settling at mode 4.
    press(1'b0, 1'b1);
    frame();
    check_out("pre_rst_settle", 4, 1, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_out("async_rst", 0, 0, 0);
    wait_cyc(2);
    rst = 1'b0;
    frame();
    check_out("post_rst_fs", 0, 0, 0);

    // Key held low across reset gives one event after release.
    @(negedge clk);
    key_next_n = 1'b0;
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(12);
    check_out("held_key_ev", 0, 0, 1);
    wait_cyc(20);
    key_next_n = 1'b1;
    wait_cyc(10);
    repeat (3) frame();
    check_out("held_key_once", 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_mode_ctrl.md
DISPLAY_MODE_CTRL -- requirements
Module: display_mode_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable samples required to accept a key level change.
REQ-002 The block SHALL have parameter MODE_MAX, default 7, meaning the highest selectable display mode; valid modes are 0..MODE_MAX.
REQ-003 The block SHALL have parameter DEFAULT_MODE, default 0, meaning the mode applied at reset.
REQ-004 The block SHALL have parameter SETTLE_FRAMES, default 2, meaning frame starts during which mute is held after a mode change (range 1..15).
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single system clock for all logic.
REQ-006 The block SHALL have port rst, input, 1 bit, meaning asynchronous, active-high reset.
REQ-007 The block SHALL have port key_next_n, input, 1 bit, meaning raw active-low push button for advancing the mode.
REQ-008 The block SHALL have port key_prev_n, input, 1 bit, meaning raw active-low push button for going back one mode.
REQ-009 The block SHALL have port vsync_in, input, 1 bit, meaning the frame sync from the video source, asynchronous to clk, active-high.
REQ-010 The block SHALL have port mode_sel, output, 4 bits, meaning the selector code driving the display channel multiplexer.
REQ-011 The block SHALL have port mute, output, 1 bit, meaning force the display data to black while high.
REQ-012 The block SHALL have port busy, output, 1 bit, meaning a mode change is pending or settling.

Function
REQ-013 vsync_in SHALL pass through a 2-flop synchronizer; a frame start is a 0->1 transition of the synchronized signal, detected as a 1-cycle pulse fs.
REQ-014 Each key SHALL be debounced independently: the accepted level changes only after DEBOUNCE_CYCLES consecutive identical raw samples that differ from the current accepted level; the counter clears on any mismatch.
REQ-015 A press event SHALL be a 1-cycle pulse on the accepted high->low transition; one press yields exactly one event regardless of hold time.
REQ-016 Events arriving in the same cycle on both keys SHALL both be ignored.
REQ-017 The target mode SHALL be computed as follows: next from MODE_MAX wraps to 0, and prev from 0 wraps to MODE_MAX; any other case is +1 or -1.
REQ-018 The FSM SHALL have states IDLE, PEND and SETTLE.
REQ-019 In IDLE, on a key event, the target SHALL be set to mode_sel plus or minus 1 with wrap, the state SHALL move to PEND, and busy SHALL rise the next cycle.
REQ-020 In PEND, a further key event SHALL retarget by stepping from the current target, not from mode_sel, with wrap.
REQ-021 In PEND, on fs, mode_sel SHALL be set to the target, mute SHALL be set to 1, the frame counter SHALL be cleared, and the state SHALL move to SETTLE; the update is registered, so it is visible the cycle after fs.
REQ-022 If a key event and fs coincide in PEND, the retargeted value SHALL be the one applied.
REQ-023 In SETTLE, each fs SHALL increment the frame counter; on the fs that brings the count to SETTLE_FRAMES, mute and busy SHALL clear the next cycle and the state SHALL return to IDLE.
REQ-024 In SETTLE, a key event SHALL set a new target and move to PEND with mute held at 1; the frame counter SHALL restart on the next application.
REQ-025 If the target equals mode_sel when fs occurs, the block SHALL still pass through SETTLE.
REQ-026 mode_sel SHALL change only on the cycle after an fs; it SHALL never change mid-frame.
REQ-027 mode_sel SHALL never exceed MODE_MAX.

Reset
REQ-028 While rst is high, the outputs SHALL be mode_sel=DEFAULT_MODE, mute=0 and busy=0, the state SHALL be IDLE, and all counters, synchronizer flops and debounced levels SHALL be cleared to the released (high) state.
REQ-029 Asserting rst in PEND or SETTLE SHALL discard the pending target immediately, asynchronously.
REQ-030 After release, a key still held low SHALL produce one event after DEBOUNCE_CYCLES.

Verification
REQ-031 The bench SHALL cover this scenario: DEBOUNCE_CYCLES=4, key_next_n glitches low for 3 cycles -> no event, busy stays 0.
REQ-032 The bench SHALL cover this scenario: mode_sel=0, next press, then vsync edge -> mode_sel=1 on the cycle after fs, mute=1; mute=0 and busy=0 after 2 further fs.
REQ-033 The bench SHALL cover this scenario: mode_sel=7, next press -> 0 applied; mode_sel=0, prev press -> 7 applied.
REQ-034 The bench SHALL cover this scenario: 3 next presses before any fs, starting from mode 2 -> single update to 5 on the first fs.
REQ-035 The bench SHALL cover this scenario: both keys pressed in the same cycle -> no event, mode unchanged.
REQ-036 The bench SHALL cover this scenario: rst pulsed in SETTLE with mode_sel=4 -> mode_sel=0, mute=0 and busy=0 while rst is high, with no update on the following fs.
